// File: rtl/exu_irf_wb2_arb.sv
// rtl/exu_irf_wb2_arb.sv - IRF write port 2 arbiter: round-robin with age escalation
//
// Purpose: picks one long-latency writeback source per cycle (0=div, 1=mul, 2=lsu)
//   to own IRF write port 2. Requests that have waited AGE_THR cycles or more
//   override round-robin order. The winner's rd/tid/data are registered onto the
//   port one cycle after the grant. starve_err latches if any request waits past
//   MAX_WAIT cycles.
// Ports:
//   clk, rst_l        core clock, asynchronous active-low reset
//   req               per-source level request, held until granted
//   req_rd/tid/data   per-source destination, thread id and write data (sliced)
//   wr2_block         port unavailable this cycle; no grant, requests keep aging
//   gnt               combinational one-hot0 grant
//   exu_irf_wen2/rd2/tid2/data2  registered IRF port 2 write
//   starve_err        sticky starvation flag, cleared only by reset
module exu_irf_wb2_arb #(
    parameter int NREQ     = 3,
    parameter int DW       = 72,
    parameter int MAX_WAIT = 5,
    parameter int AGE_THR  = 3
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NREQ-1:0]     req,
    input  logic [5*NREQ-1:0]   req_rd,
    input  logic [2*NREQ-1:0]   req_tid,
    input  logic [DW*NREQ-1:0]  req_data,
    input  logic                wr2_block,
    output logic [NREQ-1:0]     gnt,
    output logic                exu_irf_wen2,
    output logic [4:0]          exu_irf_rd2,
    output logic [1:0]          exu_irf_tid2,
    output logic [DW-1:0]       exu_irf_data2,
    output logic                starve_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] AGE_T  = 3'(AGE_THR);
    localparam logic [2:0] MAX_T  = 3'(MAX_WAIT);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [2:0]    wait_cnt_q [NREQ];
    logic [2:0]    wait_cnt_d [NREQ];
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          starve_err_q, starve_err_d;
    logic          wen2_q, wen2_d;
    logic [4:0]    rd2_q, rd2_d;
    logic [1:0]    tid2_q, tid2_d;
    logic [DW-1:0] data2_q, data2_d;

    logic          aged_hit, rr_hit, gnt_hit;
    logic [PW-1:0] aged_idx, rr_idx, gnt_idx;
    logic [2:0]    aged_cnt;

    // Winner selection. Strict '>' while scanning upward keeps the lowest index on
    // an age tie.
    always_comb begin
        aged_hit = 1'b0;
        aged_idx = '0;
        aged_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (wait_cnt_q[i] >= AGE_T) &&
                (!aged_hit || (wait_cnt_q[i] > aged_cnt))) begin
                aged_hit = 1'b1;
                aged_idx = PW'(i);
                aged_cnt = wait_cnt_q[i];
            end
        end

        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!rr_hit && req[j]) begin
                rr_hit = 1'b1;
                rr_idx = PW'(j);
            end
        end

        gnt_hit = rst_l && !wr2_block && (aged_hit || rr_hit);
        gnt_idx = aged_hit ? aged_idx : rr_idx;

        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = gnt_hit && (gnt_idx == PW'(i));
        end
    end

    // Next-state: wait counters, pointer, sticky error and the port capture.
    always_comb begin
        starve_err_d = starve_err_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || gnt[i]) begin
                wait_cnt_d[i] = 3'd0;
            end else begin
                // Waiting at MAX_WAIT and still not granted means it is about to exceed it.
                if (wait_cnt_q[i] == MAX_T) starve_err_d = 1'b1;
                wait_cnt_d[i] = (wait_cnt_q[i] == 3'd7) ? 3'd7 : wait_cnt_q[i] + 3'd1;
            end
        end

        rr_ptr_d = rr_ptr_q;
        wen2_d   = gnt_hit;
        rd2_d    = rd2_q;
        tid2_d   = tid2_q;
        data2_d  = data2_q;
        if (gnt_hit) begin
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
            rd2_d    = req_rd[5*gnt_idx +: 5];
            tid2_d   = req_tid[2*gnt_idx +: 2];
            data2_d  = req_data[DW*gnt_idx +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= 3'd0;
            rr_ptr_q     <= '0;
            starve_err_q <= 1'b0;
            wen2_q       <= 1'b0;
            rd2_q        <= '0;
            tid2_q       <= '0;
            data2_q      <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
            rr_ptr_q     <= rr_ptr_d;
            starve_err_q <= starve_err_d;
            wen2_q       <= wen2_d;
            rd2_q        <= rd2_d;
            tid2_q       <= tid2_d;
            data2_q      <= data2_d;
        end
    end

    assign exu_irf_wen2  = wen2_q;
    assign exu_irf_rd2   = rd2_q;
    assign exu_irf_tid2  = tid2_q;
    assign exu_irf_data2 = data2_q;
    assign starve_err    = starve_err_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_l) $onehot0(gnt));
    a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_l) (gnt & ~req) == '0);
    a_gnt_blocked: assert property (@(posedge clk) disable iff (!rst_l) wr2_block |-> gnt == '0);
    a_data_known:  assert property (@(posedge clk) disable iff (!rst_l)
                                    exu_irf_wen2 |-> !$isunknown(exu_irf_data2));

endmodule

// File: tb/tb_exu_irf_wb2_arb.sv
// tb/tb_exu_irf_wb2_arb.sv - self-checking bench for exu_irf_wb2_arb
module tb_exu_irf_wb2_arb;

    logic         clk = 1'b0;
    logic         rst_l;
    logic [2:0]   req;
    logic [14:0]  req_rd;
    logic [5:0]   req_tid;
    logic [215:0] req_data;
    logic         wr2_block;
    logic [2:0]   gnt;
    logic         exu_irf_wen2;
    logic [4:0]   exu_irf_rd2;
    logic [1:0]   exu_irf_tid2;
    logic [71:0]  exu_irf_data2;
    logic         starve_err;

    int n_pass  = 0;
    int n_total = 0;

    exu_irf_wb2_arb dut (
        .clk(clk), .rst_l(rst_l), .req(req), .req_rd(req_rd), .req_tid(req_tid),
        .req_data(req_data), .wr2_block(wr2_block), .gnt(gnt),
        .exu_irf_wen2(exu_irf_wen2), .exu_irf_rd2(exu_irf_rd2),
        .exu_irf_tid2(exu_irf_tid2), .exu_irf_data2(exu_irf_data2),
        .starve_err(starve_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // Behavioural model: per-source waiting age, round-robin start, port image.
    int          m_age [3];
    int          m_rr;
    logic        m_wen, m_err;
    logic [4:0]  m_rd;
    logic [1:0]  m_tid;
    logic [71:0] m_data;

    function automatic int pick();
        int best, best_age;
        best = -1; best_age = -1;
        if (!rst_l || wr2_block) return -1;
        for (int i = 0; i < 3; i++)
            if (req[i] && m_age[i] >= 3 && m_age[i] > best_age) begin
                best = i; best_age = m_age[i];
            end
        if (best >= 0) return best;
        for (int k = 0; k < 3; k++)
            if (req[(m_rr + k) % 3]) return (m_rr + k) % 3;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        if (!rst_l) begin
            for (int i = 0; i < 3; i++) m_age[i] = 0;
            m_rr = 0; m_wen = 0; m_err = 0; m_rd = 0; m_tid = 0; m_data = 0;
            chk("rst_gnt", 72'(gnt), 72'(0));
            chk("rst_outs", {exu_irf_wen2, starve_err, exu_irf_rd2, exu_irf_tid2}, 72'(0));
            chk("rst_data2", exu_irf_data2, 72'(0));
        end else begin
            g = pick();
            chk("m_gnt", 72'(gnt), (g < 0) ? 72'(0) : 72'(3'b001 << g));
            chk("m_wen2", 72'(exu_irf_wen2), 72'(m_wen));
            chk("m_rd2", 72'(exu_irf_rd2), 72'(m_rd));
            chk("m_tid2", 72'(exu_irf_tid2), 72'(m_tid));
            chk("m_data2", exu_irf_data2, m_data);
            chk("m_starve", 72'(starve_err), 72'(m_err));
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || g == i) m_age[i] = 0;
                else begin
                    if (m_age[i] == 5) m_err = 1;
                    if (m_age[i] < 7) m_age[i]++;
                end
            end
            m_wen = (g >= 0);
            if (g >= 0) begin
                m_rr   = (g + 1) % 3;
                m_rd   = req_rd[5*g +: 5];
                m_tid  = req_tid[2*g +: 2];
                m_data = req_data[72*g +: 72];
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [1:0] tid,
                           input logic [71:0] d);
        req_rd[5*i +: 5]    = rd;
        req_tid[2*i +: 2]   = tid;
        req_data[72*i +: 72] = d;
    endtask

    task automatic do_reset();
        rst_l = 1'b0; req = '0; wr2_block = 1'b0;
        tick();
        rst_l = 1'b1;
    endtask

    function automatic logic [71:0] val(input int i, input int k);
        return 72'h5A_0000_0000_0000_0000 + 72'(i * 256 + k);
    endfunction

    initial begin
        logic [2:0]  seq2 [6];
        int          cnt [3];
        int          g;
        logic [71:0] exp_d;
        logic [4:0]  exp_rd;

        seq2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_l = 1'b0; req = '0; wr2_block = 1'b0; req_rd = '0; req_tid = '0; req_data = '0;
        tick(); tick();
        rst_l = 1'b1;
        #2;
        chk("reset_wen2", 72'(exu_irf_wen2), 72'(0));
        chk("reset_starve", 72'(starve_err), 72'(0));
        tick();

        // 1: single request
        req = 3'b001; set_src(0, 5'd5, 2'd2, 72'hAA);
        #2 chk("t1_gnt", 72'(gnt), 72'(3'b001));
        tick(); req = '0;
        #2 chk("t1_wen2", 72'(exu_irf_wen2), 72'(1));
        chk("t1_rd2", 72'(exu_irf_rd2), 72'(5));
        chk("t1_tid2", 72'(exu_irf_tid2), 72'(2));
        chk("t1_data2", exu_irf_data2, 72'hAA);
        tick();
        #2 chk("t1_wen2_off", 72'(exu_irf_wen2), 72'(0));
        tick();

        // 2: all three held, new data on each grant
        do_reset();
        for (int i = 0; i < 3; i++) begin cnt[i] = 0; set_src(i, 5'(i * 4), 2'(i), val(i, 0)); end
        req = 3'b111;
        exp_d = '0; exp_rd = '0;
        for (int c = 0; c < 6; c++) begin
            #2 chk("t2_gnt", 72'(gnt), 72'(seq2[c]));
            if (c > 0) begin
                chk("t2_wen2", 72'(exu_irf_wen2), 72'(1));
                chk("t2_data2", exu_irf_data2, exp_d);
                chk("t2_rd2", 72'(exu_irf_rd2), 72'(exp_rd));
            end
            g = c % 3;
            exp_d = val(g, cnt[g]); exp_rd = 5'(g * 4 + cnt[g]);
            cnt[g]++;
            tick();
            set_src(g, 5'(g * 4 + cnt[g]), 2'(g), val(g, cnt[g]));
        end
        req = '0;
        #2 chk("t2_last_data2", exu_irf_data2, exp_d);
        chk("t2_starve", 72'(starve_err), 72'(0));
        tick();

        // 3a: blocked 5 cycles, no starvation
        do_reset();
        req = 3'b010; set_src(1, 5'd7, 2'd1, 72'h77); wr2_block = 1'b1;
        for (int c = 0; c < 5; c++) begin #2 chk("t3a_blk_gnt", 72'(gnt), 72'(0)); tick(); end
        wr2_block = 1'b0;
        #2 chk("t3a_gnt", 72'(gnt), 72'(3'b010));
        tick(); req = '0;
        #2 chk("t3a_wen2", 72'(exu_irf_wen2), 72'(1));
        chk("t3a_starve", 72'(starve_err), 72'(0));
        tick();

        // 3b: blocked 6 cycles -> starvation; then 5: async reset with wen2 pending
        do_reset();
        req = 3'b010; wr2_block = 1'b1;
        for (int c = 0; c < 6; c++) begin #2 chk("t3b_blk_gnt", 72'(gnt), 72'(0)); tick(); end
        wr2_block = 1'b0;
        #2 chk("t3b_starve_set", 72'(starve_err), 72'(1));
        chk("t3b_gnt", 72'(gnt), 72'(3'b010));
        tick(); req = '0;
        #2 chk("t3b_starve_sticky", 72'(starve_err), 72'(1));
        chk("t5_wen2_pending", 72'(exu_irf_wen2), 72'(1));
        rst_l = 1'b0;
        #1 chk("t5_rst_wen2", 72'(exu_irf_wen2), 72'(0));
        chk("t5_rst_rd2", 72'(exu_irf_rd2), 72'(0));
        chk("t5_rst_data2", exu_irf_data2, 72'(0));
        chk("t5_rst_starve", 72'(starve_err), 72'(0));
        tick(); rst_l = 1'b1;
        tick();
        #2 chk("t5_post_wen2", 72'(exu_irf_wen2), 72'(0));
        tick();

        // 4: aged requester overrides round-robin
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 5'(10 + i), 2'(i), val(i, 9));
        req = 3'b100; wr2_block = 1'b1;
        tick(); tick(); tick();
        wr2_block = 1'b0; req = 3'b111;
        #2 chk("t4_gnt_aged", 72'(gnt), 72'(3'b100));
        tick();
        #2 chk("t4_gnt_rr0", 72'(gnt), 72'(3'b001));
        tick();
        #2 chk("t4_gnt_rr1", 72'(gnt), 72'(3'b010));
        tick(); req = '0;
        tick();

        // 6: single source back-to-back
        do_reset();
        req = 3'b001;
        for (int c = 0; c < 4; c++) begin
            set_src(0, 5'(20 + c), 2'd3, val(0, 100 + c));
            #2 chk("t6_gnt", 72'(gnt), 72'(3'b001));
            if (c > 0) chk("t6_data2", exu_irf_data2, val(0, 99 + c));
            tick();
        end
        req = '0;
        #2 chk("t6_last_data2", exu_irf_data2, val(0, 103));
        chk("t6_last_rd2", 72'(exu_irf_rd2), 72'(23));
        chk("t6_starve", 72'(starve_err), 72'(0));
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
